// File: rtl/guess_pkg.sv
// Shared types and helpers for the number-guessing game controller.
// Holds the FSM/result encodings and the BCD digit increment.
package guess_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_CHECK = 3'd2,
      ST_SHOW  = 3'd3,
      ST_WIN   = 3'd4,
      ST_LOSE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_LOW   = 2'd1,
      RES_HIGH  = 2'd2,
      RES_EQUAL = 2'd3
   } result_t;

   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
      return (d == 4'd9) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that holds the result display; done is high at zero.
// A load wins over the decrement, and the count rests at zero until reloaded.
module hold_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/guess_entry_ctrl.sv
// Game controller: builds a BCD guess from button pulses, compares it with the
// latched secret, counts attempts and sequences SHOW / WIN / LOSE.
module guess_entry_ctrl
   import guess_pkg::*;
#(
   parameter int NUM_DIGITS    = 2,
   parameter int MAX_TRIES     = 7,
   parameter int RESULT_CYCLES = 25_000_000,
   localparam int DSEL_W = $clog2(NUM_DIGITS),
   localparam int GW     = BCD_W * NUM_DIGITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        btn_rise,
   input  logic [GW-1:0]     secret_bcd,
   input  logic              secret_valid,
   output logic [GW-1:0]     guess_bcd,
   output logic [DSEL_W-1:0] digit_sel,
   output result_t           result,
   output logic [3:0]        tries,
   output state_t            state
);

   localparam int TW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

   state_t            state_nx;
   result_t           result_nx, cmp;
   logic [GW-1:0]     secret_q, secret_nx, guess_nx;
   logic [DSEL_W-1:0] dsel_nx;
   logic [3:0]        tries_nx, tries_inc;
   logic              timer_load, timer_done;

   hold_timer #(.W(TW)) u_hold_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (TW'(RESULT_CYCLES - 1)),
      .done     (timer_done)
   );

   // Packed BCD compares correctly as a plain unsigned number.
   always_comb begin
      if (guess_bcd == secret_q)     cmp = RES_EQUAL;
      else if (guess_bcd < secret_q) cmp = RES_LOW;
      else                           cmp = RES_HIGH;
   end

   assign tries_inc = (tries == 4'd15) ? 4'd15 : tries + 4'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         secret_q  <= '0;
         guess_bcd <= '0;
         digit_sel <= '0;
         result    <= RES_NONE;
         tries     <= '0;
      end else begin
         state     <= state_nx;
         secret_q  <= secret_nx;
         guess_bcd <= guess_nx;
         digit_sel <= dsel_nx;
         result    <= result_nx;
         tries     <= tries_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      secret_nx  = secret_q;
      guess_nx   = guess_bcd;
      dsel_nx    = digit_sel;
      result_nx  = result;
      tries_nx   = tries;
      timer_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (secret_valid) begin
               secret_nx = secret_bcd;
               guess_nx  = '0;
               dsel_nx   = '0;
               tries_nx  = '0;
               result_nx = RES_NONE;
               state_nx  = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            if (btn_rise[2]) begin
               state_nx = ST_CHECK;
            end else if (btn_rise[1]) begin
               dsel_nx = (digit_sel == DSEL_W'(NUM_DIGITS - 1)) ? '0 : digit_sel + DSEL_W'(1);
            end else if (btn_rise[0]) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (digit_sel == DSEL_W'(i))
                     guess_nx[i*BCD_W +: BCD_W] = bcd_inc(guess_bcd[i*BCD_W +: BCD_W]);
               end
            end
         end
         ST_CHECK: begin
            result_nx = cmp;
            tries_nx  = tries_inc;
            if (cmp == RES_EQUAL) begin
               state_nx = ST_WIN;
            end else if (tries_inc == 4'(MAX_TRIES)) begin
               state_nx = ST_LOSE;
            end else begin
               state_nx   = ST_SHOW;
               timer_load = 1'b1;
            end
         end
         ST_SHOW: begin
            if (timer_done) begin
               state_nx = ST_ENTRY;
               guess_nx = '0;
               dsel_nx  = '0;
            end
         end
         ST_WIN, ST_LOSE: begin
            if (btn_rise[2]) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Directed bench for guess_entry_ctrl with NUM_DIGITS=2, MAX_TRIES=3, RESULT_CYCLES=4.
module tb_guess_entry_ctrl;
   import guess_pkg::*;

   logic       clk;
   logic       reset;
   logic [2:0] btn_rise;
   logic [7:0] secret_bcd;
   logic       secret_valid;
   logic [7:0] guess_bcd;
   logic [0:0] digit_sel;
   result_t    result;
   logic [3:0] tries;
   state_t     state;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic [2:0] btn;
      logic [7:0] exp_guess;
      logic [0:0] exp_dsel;
      state_t     exp_state;
   } vec_t;

   vec_t vecs[$];

   guess_entry_ctrl #(
      .NUM_DIGITS    (2),
      .MAX_TRIES     (3),
      .RESULT_CYCLES (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_rise     (btn_rise),
      .secret_bcd   (secret_bcd),
      .secret_valid (secret_valid),
      .guess_bcd    (guess_bcd),
      .digit_sel    (digit_sel),
      .result       (result),
      .tries        (tries),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [2:0] b);
      btn_rise = b;
      tick();
      btn_rise = 3'b000;
   endtask

   task automatic add_vec(input logic [2:0] b, input logic [7:0] g, input logic [0:0] d, input state_t s);
      vec_t v;
      v.btn = b; v.exp_guess = g; v.exp_dsel = d; v.exp_state = s;
      vecs.push_back(v);
   endtask

   // Starts from guess 0x00, digit 0; leaves the DUT in CHECK.
   task automatic enter_guess(input logic [3:0] tens, input logic [3:0] ones);
      for (int i = 0; i < ones; i++) pulse(3'b001);
      pulse(3'b010);
      for (int i = 0; i < tens; i++) pulse(3'b001);
      check("guess_before_submit", 32'(guess_bcd), {24'd0, tens, ones});
      pulse(3'b100);
      check("state_check", 32'(state), 32'(ST_CHECK));
   endtask

   task automatic wait_state(input state_t s, input int budget);
      int n = 0;
      while (state != s && n < budget) begin
         tick();
         n++;
      end
      check("wait_state", 32'(state), 32'(s));
   endtask

   task automatic start_game(input logic [7:0] sec);
      secret_bcd   = sec;
      secret_valid = 1'b1;
      tick();
      secret_valid = 1'b0;
      check("start_state", 32'(state), 32'(ST_ENTRY));
      check("start_guess", 32'(guess_bcd), 32'h00);
      check("start_tries", 32'(tries), 32'd0);
      check("start_result", 32'(result), 32'(RES_NONE));
   endtask

   initial begin
      reset        = 1'b0;
      btn_rise     = 3'b000;
      secret_bcd   = 8'h42;
      secret_valid = 1'b0;

      // digit edits: ten incs wrap 9->0, two nexts wrap digit_sel, then build 0x37
      for (int i = 1; i <= 9; i++) add_vec(3'b001, 8'(i), 1'b0, ST_ENTRY);
      add_vec(3'b001, 8'h00, 1'b0, ST_ENTRY);
      add_vec(3'b010, 8'h00, 1'b1, ST_ENTRY);
      add_vec(3'b010, 8'h00, 1'b0, ST_ENTRY);
      for (int i = 1; i <= 7; i++) add_vec(3'b001, 8'(i), 1'b0, ST_ENTRY);
      add_vec(3'b010, 8'h07, 1'b1, ST_ENTRY);
      add_vec(3'b001, 8'h17, 1'b1, ST_ENTRY);
      add_vec(3'b001, 8'h27, 1'b1, ST_ENTRY);
      add_vec(3'b001, 8'h37, 1'b1, ST_ENTRY);
      add_vec(3'b100, 8'h37, 1'b1, ST_CHECK);

      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      tick();
      check("rst_state", 32'(state), 32'(ST_IDLE));
      check("rst_guess", 32'(guess_bcd), 32'h00);
      check("rst_dsel", 32'(digit_sel), 32'd0);
      check("rst_result", 32'(result), 32'(RES_NONE));
      check("rst_tries", 32'(tries), 32'd0);
      pulse(3'b011);
      check("idle_ignores_btn", 32'(guess_bcd), 32'h00);
      check("idle_stays", 32'(state), 32'(ST_IDLE));

      start_game(8'h42);
      secret_bcd = 8'h99;  // must not be re-sampled during the game

      foreach (vecs[k]) begin
         pulse(vecs[k].btn);
         check($sformatf("vec%0d_guess", k), 32'(guess_bcd), 32'(vecs[k].exp_guess));
         check($sformatf("vec%0d_dsel", k), 32'(digit_sel), 32'(vecs[k].exp_dsel));
         check($sformatf("vec%0d_state", k), 32'(state), 32'(vecs[k].exp_state));
      end

      // CHECK lasts one cycle, then SHOW for exactly 4 cycles
      tick();
      check("c1_result", 32'(result), 32'(RES_LOW));
      check("c1_tries", 32'(tries), 32'd1);
      check("show_1", 32'(state), 32'(ST_SHOW));
      pulse(3'b001);
      check("show_2", 32'(state), 32'(ST_SHOW));
      check("show_drops_inc", 32'(guess_bcd), 32'h37);
      tick();
      check("show_3", 32'(state), 32'(ST_SHOW));
      tick();
      check("show_4", 32'(state), 32'(ST_SHOW));
      tick();
      check("show_exit", 32'(state), 32'(ST_ENTRY));
      check("show_exit_guess", 32'(guess_bcd), 32'h00);
      check("show_exit_dsel", 32'(digit_sel), 32'd0);
      check("show_keeps_result", 32'(result), 32'(RES_LOW));

      // win path against the originally latched secret
      enter_guess(4'd4, 4'd2);
      tick();
      check("win_state", 32'(state), 32'(ST_WIN));
      check("win_result", 32'(result), 32'(RES_EQUAL));
      check("win_tries", 32'(tries), 32'd2);
      pulse(3'b001);
      pulse(3'b010);
      check("win_frozen_guess", 32'(guess_bcd), 32'h42);
      check("win_frozen_state", 32'(state), 32'(ST_WIN));
      pulse(3'b100);
      check("win_ack_idle", 32'(state), 32'(ST_IDLE));
      check("win_ack_tries", 32'(tries), 32'd2);

      // lose path
      start_game(8'h42);
      enter_guess(4'd5, 4'd0);
      tick();
      check("l1_result", 32'(result), 32'(RES_HIGH));
      check("l1_tries", 32'(tries), 32'd1);
      wait_state(ST_ENTRY, 10);
      enter_guess(4'd1, 4'd0);
      tick();
      check("l2_result", 32'(result), 32'(RES_LOW));
      check("l2_tries", 32'(tries), 32'd2);
      wait_state(ST_ENTRY, 10);
      enter_guess(4'd9, 4'd9);
      tick();
      check("l3_result", 32'(result), 32'(RES_HIGH));
      check("l3_tries", 32'(tries), 32'd3);
      check("lose_state", 32'(state), 32'(ST_LOSE));
      pulse(3'b011);
      check("lose_frozen", 32'(guess_bcd), 32'h99);
      pulse(3'b100);
      check("lose_ack_idle", 32'(state), 32'(ST_IDLE));

      // simultaneous pulses: submit wins, guess untouched
      start_game(8'h42);
      pulse(3'b001);
      pulse(3'b111);
      check("prio_state", 32'(state), 32'(ST_CHECK));
      check("prio_guess", 32'(guess_bcd), 32'h01);
      check("prio_dsel", 32'(digit_sel), 32'd0);
      tick();
      check("prio_show", 32'(state), 32'(ST_SHOW));
      tick();

      // asynchronous reset mid-SHOW, away from any clock edge
      #2 reset = 1'b0;
      #1;
      check("arst_state", 32'(state), 32'(ST_IDLE));
      check("arst_guess", 32'(guess_bcd), 32'h00);
      check("arst_result", 32'(result), 32'(RES_NONE));
      check("arst_tries", 32'(tries), 32'd0);
      check("arst_dsel", 32'(digit_sel), 32'd0);
      reset = 1'b1;
      tick();
      check("post_arst_idle", 32'(state), 32'(ST_IDLE));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
